// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8 controller: FSM states,
// ALUControl codes and the opcodes the controller decodes.
package ctrl_pkg;

  localparam int OP_W   = 11;
  localparam int ALUC_W = 4;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ILLEGAL  = 4'd9
  } state_t;

  localparam logic [ALUC_W-1:0] ALUC_AND   = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_ORR   = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_ADD   = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_SUB   = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_PASSB = 4'b0111;

  localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OP_W-1:0] OP_CBZ  = 11'b10110100000;

  // CBZ carries part of the register field in its low three opcode bits
  function automatic logic is_cbz(input logic [OP_W-1:0] op);
    return op[OP_W-1:3] == OP_CBZ[OP_W-1:3];
  endfunction

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// R-type opcode to ALUControl decode; anything unrecognised falls back to ADD.
module alu_op_dec
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  output logic [ALUC_W-1:0] aluc
);

  always_comb begin
    aluc = ALUC_ADD;
    case (op)
      OP_ADD:  aluc = ALUC_ADD;
      OP_SUB:  aluc = ALUC_SUB;
      OP_AND:  aluc = ALUC_AND;
      OP_ORR:  aluc = ALUC_ORR;
      default: aluc = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM driving the datapath enables, selects and ALUControl.
// Optional build macro CTRL_ILLEGAL_TRAP_EN turns ILLEGAL into a sticky halt with illegal_op.
//
//  state    | meaning
//  FETCH    | read instruction, PC <= PC + 4
//  DECODE   | read registers, ALUOut <= branch target, dispatch on Op
//  MEMADR   | compute load/store address
//  MEMREAD  | read data memory
//  MEMWB    | write loaded data to register file
//  MEMWRITE | write register data to memory
//  EXEC_R   | R-type ALU operation
//  ALUWB    | write ALU result to register file
//  BRANCH   | CBZ: test Rt against zero, take branch from ALUOut
//  ILLEGAL  | unknown opcode: NOP, or halt when trapping is built in
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Op,
  input  logic              zero,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic              PCWrite,
  output logic              PCSrc,
  output logic              IRWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              Reg2Loc,
  output logic              instr_done
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  state_t state, state_nxt;
  logic [ALUC_W-1:0] rtype_aluc;

  alu_op_dec u_alu_op_dec (
    .op   (Op),
    .aluc (rtype_aluc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = FETCH;
    ALUControl = ALUC_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Reg2Loc    = 1'b0;
    instr_done = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (state)
      FETCH: begin
        MemRead   = 1'b1;
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b01;
        PCWrite   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        Reg2Loc = (Op == OP_STUR) || is_cbz(Op);
        if ((Op == OP_LDUR) || (Op == OP_STUR)) state_nxt = MEMADR;
        else if (is_rtype(Op))                  state_nxt = EXEC_R;
        else if (is_cbz(Op))                    state_nxt = BRANCH;
        else                                    state_nxt = ILLEGAL;
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        // a corrupted Op here degrades to a load, never to a spurious store
        state_nxt = (Op == OP_STUR) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        MemRead   = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        MemWrite   = 1'b1;
        Reg2Loc    = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = rtype_aluc;
        state_nxt  = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        Reg2Loc    = 1'b1;
        ALUControl = ALUC_PASSB;
        PCWrite    = zero;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
      end
      ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
        state_nxt  = ILLEGAL;
`else
        instr_done = 1'b1;
`endif
      end
      default: state_nxt = FETCH;
    endcase

    // reset overrides everything so no enable can fire on the abandoned instruction
    if (reset) begin
      ALUControl = ALUC_ADD;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      Reg2Loc    = 1'b0;
      instr_done = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_op = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; expected per-cycle output vectors
// are queued per instruction and popped on each falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        zero;
  logic [3:0]  ALUControl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        PCWrite, PCSrc, IRWrite, MemRead, MemWrite;
  logic        MemtoReg, RegWrite, Reg2Loc, instr_done;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .zero       (zero),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .Reg2Loc    (Reg2Loc),
    .instr_done (instr_done)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] ADDI = 11'b10001011000;
  localparam logic [10:0] SUBI = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORRI = 11'b10101010000;
  localparam logic [10:0] CBZ5 = 11'b10110100101;
  localparam logic [10:0] CBZ2 = 11'b10110100010;
  localparam logic [10:0] BADOP = 11'b00000000000;

  typedef enum int {T_RST, T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_EX, T_AWB, T_BR, T_ILL} tst_t;
  typedef struct {
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic is_cbz_op(input logic [10:0] op);
    logic [10:0] t;
    t = op;
    return t[10:3] == 8'b10110100;
  endfunction

  function automatic logic [3:0] rtype_code(input logic [10:0] op);
    case (op)
      SUBI:    return 4'b0110;
      ANDI:    return 4'b0000;
      ORRI:    return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  // Expected outputs per control step, written straight from the behaviour description
  function automatic logic [15:0] exp_vec(input tst_t s, input logic [10:0] op, input logic z);
    logic [3:0] alu;
    logic       sa, pcw, pcs, irw, mr, mw, m2r, rw, r2l, dn;
    logic [1:0] sb_sel;
    alu = 4'b0010; sa = 0; sb_sel = 2'b00; pcw = 0; pcs = 0; irw = 0;
    mr = 0; mw = 0; m2r = 0; rw = 0; r2l = 0; dn = 0;
    case (s)
      T_F:   begin mr = 1; irw = 1; sb_sel = 2'b01; pcw = 1; end
      T_D:   begin sb_sel = 2'b11; r2l = (op == STUR) || is_cbz_op(op); end
      T_MA:  begin sa = 1; sb_sel = 2'b10; end
      T_MR:  mr = 1;
      T_MWB: begin rw = 1; m2r = 1; dn = 1; end
      T_MW:  begin mw = 1; r2l = 1; dn = 1; end
      T_EX:  begin sa = 1; alu = rtype_code(op); end
      T_AWB: begin rw = 1; dn = 1; end
      T_BR:  begin r2l = 1; alu = 4'b0111; pcw = z; pcs = 1; dn = 1; end
`ifdef CTRL_ILLEGAL_TRAP_EN
      T_ILL: ;
`else
      T_ILL: dn = 1;
`endif
      default: ;
    endcase
    return {alu, sa, sb_sel, pcw, pcs, irw, mr, mw, m2r, rw, r2l, dn};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {ALUControl, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IRWrite, MemRead,
            MemWrite, MemtoReg, RegWrite, Reg2Loc, instr_done};
  endfunction

  task automatic push(input tst_t s, input logic [10:0] op, input logic z, input string tag);
    exp_t e;
    e.v   = exp_vec(s, op, z);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_cycle();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs_vec());
    end else begin
      e = sb.pop_front();
      chk(e.tag, {16'h0, obs_vec()}, {16'h0, e.v});
    end
  endtask

  task automatic run_instr(input string name, input logic [10:0] op, input logic z,
                           input logic [10:0] fetch_op);
    tst_t path[$];
    int   rw_cnt, mw_cnt, done_at, exp_rw, exp_mw, exp_done;
    if (op == LDUR)            path = '{T_F, T_D, T_MA, T_MR, T_MWB};
    else if (op == STUR)       path = '{T_F, T_D, T_MA, T_MW};
    else if (is_cbz_op(op))    path = '{T_F, T_D, T_BR};
    else if (op == ADDI || op == SUBI || op == ANDI || op == ORRI)
                               path = '{T_F, T_D, T_EX, T_AWB};
    else                       path = '{T_F, T_D, T_ILL};
    foreach (path[i]) push(path[i], op, z, $sformatf("%s_step%0d", name, i));
    exp_rw   = (op == STUR || is_cbz_op(op) || path.size() == 3) ? 0 : 1;
    exp_mw   = (op == STUR) ? 1 : 0;
    exp_done = path.size();
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (path[path.size()-1] == T_ILL) exp_done = 0;
`endif
    rw_cnt = 0; mw_cnt = 0; done_at = 0;
    Op   = fetch_op;
    zero = z;
    for (int i = 0; i < path.size(); i++) begin
      @(negedge clk);
      check_cycle();
      rw_cnt += int'(RegWrite);
      mw_cnt += int'(MemWrite);
      if (instr_done && done_at == 0) done_at = i + 1;
      if (i == 0) Op = op;
    end
    chk({name, "_regwrite_cycles"}, rw_cnt, exp_rw);
    chk({name, "_memwrite_cycles"}, mw_cnt, exp_mw);
    chk({name, "_done_cycle"}, done_at, exp_done);
  endtask

  initial begin
    reset = 1'b1;
    Op    = BADOP;
    zero  = 1'b0;

    push(T_RST, Op, zero, "reset_c0");
    push(T_RST, Op, zero, "reset_c1");
    repeat (2) begin
      @(negedge clk);
      check_cycle();
    end
    @(posedge clk); #1 reset = 1'b0;

    // Op in FETCH deliberately differs from the real opcode
    run_instr("add", ADDI, 1'b0, LDUR);
    run_instr("sub", SUBI, 1'b1, STUR);
    run_instr("and", ANDI, 1'b0, CBZ5);
    run_instr("orr", ORRI, 1'b0, BADOP);
    run_instr("ldur", LDUR, 1'b0, ADDI);
    run_instr("stur", STUR, 1'b1, LDUR);
    run_instr("cbz_taken", CBZ5, 1'b1, STUR);
    run_instr("cbz_not_taken", CBZ2, 1'b0, ADDI);
    run_instr("illegal", BADOP, 1'b0, ADDI);

`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      push(T_ILL, Op, zero, $sformatf("trap_hold%0d", i));
      @(negedge clk);
      check_cycle();
      chk("trap_illegal_op", illegal_op, 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    push(T_RST, Op, zero, "trap_reset");
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1 reset = 1'b0;
    run_instr("after_trap", ADDI, 1'b0, ADDI);
    chk("trap_cleared", illegal_op, 0);
`endif

    // abandon a load while it sits in MEMREAD
    Op = LDUR;
    push(T_F,  LDUR, 1'b0, "abort_fetch");
    push(T_D,  LDUR, 1'b0, "abort_decode");
    push(T_MA, LDUR, 1'b0, "abort_memadr");
    repeat (3) begin
      @(negedge clk);
      check_cycle();
    end
    @(posedge clk); #1 reset = 1'b1;
    push(T_RST, LDUR, 1'b0, "abort_in_reset");
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1 reset = 1'b0;
    run_instr("post_abort_add", ADDI, 1'b0, LDUR);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
